fv_fifo_push_arb: RTL and testbench
===================================

Name: fv_fifo_push_arb

Overview:
Round-robin arbiter and occupancy controller that shares the single push port of a formal-environment FIFO between several requesters. Each cycle it selects at most one valid requester and drives the FIFO push and push data. It tracks FIFO occupancy from the push and pop it sees, and blocks pushes when the FIFO is full. It also flags protocol errors (pop while empty) for use as formal assertion targets.

Parameters:
width, 8, data bits per entry
depth, 8, FIFO entries controlled; must be >= 2
inputs, 4, number of requesters; must be >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_vld  input  inputs  per-requester valid
req_data  input  inputs*width  requester i data at bits [i*width +: width]
req_rdy  output  inputs  one-hot grant; transfer for requester i when req_vld[i] & req_rdy[i]
fifo_push  output  1  push strobe to FIFO
fifo_push_data  output  width  data of granted requester
fifo_push_src  output  $clog2(inputs)  index of granted requester
fifo_pop  input  1  pop performed by FIFO consumer this cycle
count  output  $clog2(depth+1)  registered occupancy
full  output  1  count == depth
empty  output  1  count == 0
underflow_err  output  1  sticky: pop seen while empty

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset: count=0, rr_ptr=0, underflow_err=0. So full=0 and empty=1; req_rdy, fifo_push, fifo_push_data and fifo_push_src follow the combinational rules below.
- Arbitration is combinational and zero-latency: a grant in cycle N pushes in cycle N.
  - Search order starts at rr_ptr, then rr_ptr+1, ..., wrapping modulo inputs.
  - The first i with req_vld[i]=1 is granted.
- If full=1, no grant: req_rdy=0 and fifo_push=0, regardless of a same-cycle fifo_pop (full is decided from registered count).
- fifo_push = |req_vld & ~full.
- req_rdy: exactly one bit set when fifo_push=1; all zero otherwise.
- fifo_push_data: req_data slice of the granted requester; 0 when no grant.
- fifo_push_src: granted index; 0 when no grant.
- req_rdy must not depend on req_data.
- rr_ptr update:
  - On a push with grant g, next rr_ptr = (g == inputs-1) ? 0 : g+1.
  - With no push, rr_ptr holds.
- Fairness: a requester holding req_vld=1 while full=0 is granted within inputs pushes.
- count update, all at posedge:
  - push only: +1.
  - effective pop only: -1.
  - push and effective pop together: unchanged.
  - Effective pop = fifo_pop & ~empty.
- Pop while empty (fifo_pop=1, count=0):
  - count stays 0 (no wrap to all-ones).
  - underflow_err sets to 1 next cycle and holds until reset.
- Push while empty with pop in the same cycle: pop is ignored (empty=1), count becomes 1, underflow_err sets.
- count never exceeds depth: the push is blocked at full, and an effective pop at full takes count to depth-1.
- Reset mid-traffic: count, rr_ptr and underflow_err clear on the next edge. The attached FIFO is reset by the same signal, so the two stay consistent.
- No state machine beyond rr_ptr, count and underflow_err; all are registered, the rest is combinational.

Test Plan:
1. Reset, then all req_vld=0 -> empty=1, full=0, count=0, fifo_push=0, req_rdy=0, underflow_err=0.
2. inputs=4; req_vld=4'b1111 held with fifo_pop=0; req_data[i]=8'h10+i:
   - Grants 0,1,2,3,0,1,2,3 on consecutive cycles; fifo_push_data 10,11,12,13,10,11,12,13.
   - count reaches 8 and full=1 after the 8th push.
   - Next cycle req_rdy=0 and fifo_push=0.
3. Full (count=8), req_vld=4'b0100 and fifo_pop=1 in the same cycle -> no grant that cycle, count=7. Next cycle grant bit 2, fifo_push_src=2, count stays 7 only if fifo_pop=1 again, else goes to 8.
4. rr_ptr=3, req_vld=4'b0011 -> grant 0 (wrap), then rr_ptr=1 so grant 1 next cycle.
5. Empty, fifo_pop=1 for one cycle -> count stays 0; underflow_err=1 from next cycle through 10 idle cycles. Assert reset -> underflow_err=0.
6. count=3, continuous push from requester 1 with fifo_pop=1 each cycle for 5 cycles -> count stays 3. Then reset asserted mid-stream -> count=0, next grant starts search at requester 0.

Source files
------------

// File: rtl/fv_fifo_push_arb.sv
// Round-robin push-port arbiter for a shared FIFO, with occupancy tracking,
// full back-pressure and a sticky pop-while-empty flag for formal checks.
module fv_fifo_push_arb #(
    parameter int unsigned width  = 8,
    parameter int unsigned depth  = 8,
    parameter int unsigned inputs = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [inputs-1:0]           req_vld,
    input  logic [inputs*width-1:0]     req_data,
    output logic [inputs-1:0]           req_rdy,
    output logic                        fifo_push,
    output logic [width-1:0]            fifo_push_data,
    output logic [$clog2(inputs)-1:0]   fifo_push_src,
    input  logic                        fifo_pop,
    output logic [$clog2(depth+1)-1:0]  count,
    output logic                        full,
    output logic                        empty,
    output logic                        underflow_err
);

    localparam int unsigned SW = $clog2(inputs);
    localparam int unsigned CW = $clog2(depth + 1);

    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;

    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic          eff_pop;
    int unsigned   idx;

    assign count         = count_q;
    assign underflow_err = underflow_q;
    assign full          = (count_q == CW'(depth));
    assign empty         = (count_q == '0);
    assign eff_pop       = fifo_pop & ~empty;

    // Rotating priority search starting at rr_ptr; only req_vld takes part.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < int'(inputs); k++) begin
            idx = (int'(rr_ptr_q) + k) % inputs;
            if (!grant_found && req_vld[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(idx);
            end
        end
    end

    always_comb begin
        fifo_push      = grant_found & ~full;
        req_rdy        = '0;
        fifo_push_data = '0;
        fifo_push_src  = '0;
        if (fifo_push) begin
            req_rdy        = inputs'(1) << grant_idx;
            fifo_push_data = req_data[int'(grant_idx)*width +: width];
            fifo_push_src  = grant_idx;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fifo_push) begin
            rr_ptr_d = (grant_idx == SW'(inputs - 1)) ? '0 : grant_idx + SW'(1);
        end

        count_d = count_q;
        unique case ({fifo_push, eff_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        underflow_d = underflow_q | (fifo_pop & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fv_fifo_push_arb.sv
// Table-driven bench for fv_fifo_push_arb with a few hand-written multi-cycle
// sequences; inputs change on negedge and outputs are sampled 1ns later.
module tb_fv_fifo_push_arb;

    localparam int W = 8;
    localparam int D = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           fifo_push;
    logic [W-1:0]   fifo_push_data;
    logic [1:0]     fifo_push_src;
    logic           fifo_pop;
    logic [3:0]     count;
    logic           full;
    logic           empty;
    logic           underflow_err;

    fv_fifo_push_arb #(.width(W), .depth(D), .inputs(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_vld        (req_vld),
        .req_data       (req_data),
        .req_rdy        (req_rdy),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_push_src  (fifo_push_src),
        .fifo_pop       (fifo_pop),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] vld;
        logic       pop;
        logic [3:0] rdy;
        logic       push;
        logic [1:0] src;
        logic [7:0] data;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       uerr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Expected outputs are those seen during the cycle, before the next edge.
    task automatic add(input string nm, input logic rst, input logic [3:0] vld, input logic pop,
                       input logic [3:0] rdy, input logic [1:0] src, input logic [7:0] data,
                       input logic [3:0] cnt, input logic uerr);
        vec_t v;
        v.name  = nm;
        v.rst   = rst;
        v.vld   = vld;
        v.pop   = pop;
        v.rdy   = rdy;
        v.push  = |rdy;
        v.src   = src;
        v.data  = data;
        v.cnt   = cnt;
        v.full  = (cnt == 4'(D));
        v.empty = (cnt == 4'd0);
        v.uerr  = uerr;
        vecs.push_back(v);
    endtask

    task automatic check(input vec_t v);
        n_vec++;
        if ({req_rdy, fifo_push, fifo_push_src, fifo_push_data, count, full, empty, underflow_err}
            !== {v.rdy, v.push, v.src, v.data, v.cnt, v.full, v.empty, v.uerr}) begin
            n_err++;
            $display("FAIL %s: got rdy=%b push=%b src=%0d data=%h cnt=%0d full=%b empty=%b uerr=%b, want rdy=%b push=%b src=%0d data=%h cnt=%0d full=%b empty=%b uerr=%b",
                     v.name, req_rdy, fifo_push, fifo_push_src, fifo_push_data, count, full,
                     empty, underflow_err, v.rdy, v.push, v.src, v.data, v.cnt, v.full,
                     v.empty, v.uerr);
        end
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h10 + i);
    endtask

    initial begin
        vec_t v;
        reset    = 1'b1;
        req_vld  = '0;
        fifo_pop = 1'b0;
        set_default_data();

        // Reset state
        add("reset_idle", 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        // Round-robin fill to full
        add("fill0", 0, 4'b1111, 0, 4'b0001, 0, 8'h10, 0, 0);
        add("fill1", 0, 4'b1111, 0, 4'b0010, 1, 8'h11, 1, 0);
        add("fill2", 0, 4'b1111, 0, 4'b0100, 2, 8'h12, 2, 0);
        add("fill3", 0, 4'b1111, 0, 4'b1000, 3, 8'h13, 3, 0);
        add("fill4", 0, 4'b1111, 0, 4'b0001, 0, 8'h10, 4, 0);
        add("fill5", 0, 4'b1111, 0, 4'b0010, 1, 8'h11, 5, 0);
        add("fill6", 0, 4'b1111, 0, 4'b0100, 2, 8'h12, 6, 0);
        add("fill7", 0, 4'b1111, 0, 4'b1000, 3, 8'h13, 7, 0);
        add("full_block", 0, 4'b1111, 0, 4'b0000, 0, 8'h00, 8, 0);
        // Pop at full: still blocked this cycle, count drops to 7
        add("full_pop", 0, 4'b0100, 1, 4'b0000, 0, 8'h00, 8, 0);
        add("after_pop", 0, 4'b0100, 0, 4'b0100, 2, 8'h12, 7, 0);
        add("full_pop2", 0, 4'b0000, 1, 4'b0000, 0, 8'h00, 8, 0);
        // rr_ptr=3 with requesters 0,1: wrap to 0 then 1
        add("wrap_g0", 0, 4'b0011, 1, 4'b0001, 0, 8'h10, 7, 0);
        add("wrap_g1", 0, 4'b0011, 1, 4'b0010, 1, 8'h11, 7, 0);
        // Reset then pop while empty
        add("rst_mid", 1, 4'b0000, 0, 4'b0000, 0, 8'h00, 7, 0);
        add("pop_empty", 0, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++)
            add($sformatf("uerr_hold%0d", i), 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1);
        add("uerr_rst", 1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1);
        add("uerr_clr", 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        // Push and pop while empty: pop ignored, flag set
        add("push_pop_empty", 0, 4'b0001, 1, 4'b0001, 0, 8'h10, 0, 0);
        add("pp_empty_after", 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 1);
        // Build count=3, then steady push+pop
        add("to3_a", 0, 4'b0010, 0, 4'b0010, 1, 8'h11, 1, 1);
        add("to3_b", 0, 4'b0010, 0, 4'b0010, 1, 8'h11, 2, 1);
        for (int i = 0; i < 5; i++)
            add($sformatf("steady%0d", i), 0, 4'b0010, 1, 4'b0010, 1, 8'h11, 3, 1);
        add("rst_stream", 1, 4'b0010, 1, 4'b0010, 1, 8'h11, 3, 1);
        add("post_rst_g0", 0, 4'b1111, 0, 4'b0001, 0, 8'h10, 0, 0);
        add("post_rst_g1", 0, 4'b1010, 0, 4'b0010, 1, 8'h11, 1, 0);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            req_vld  = vecs[i].vld;
            fifo_pop = vecs[i].pop;
            #1;
            check(vecs[i]);
        end

        // Grant must not move with req_data; data follows the granted slice.
        // State here: count=2, rr_ptr=2.
        @(negedge clk);
        reset    = 1'b0;
        req_vld  = 4'b0100;
        fifo_pop = 1'b0;
        req_data = {8'h01, 8'hA5, 8'h02, 8'h03};
        #1;
        add("data_a", 0, 4'b0100, 0, 4'b0100, 2, 8'hA5, 2, 0);
        v = vecs[$];
        check(v);
        req_data = {8'hFF, 8'h5A, 8'hEE, 8'hDD};
        #1;
        add("data_b", 0, 4'b0100, 0, 4'b0100, 2, 8'h5A, 2, 0);
        v = vecs[$];
        check(v);
        set_default_data();

        // Fill from count=3, rr_ptr=3: grants 3,0,1,2,3 then blocked at full.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_vld = 4'b1111;
            #1;
            add($sformatf("rr_fill%0d", k), 0, 4'b1111, 0, 4'(1 << ((3 + k) % N)),
                2'((3 + k) % N), 8'(8'h10 + (3 + k) % N), 4'(3 + k), 0);
            v = vecs[$];
            check(v);
        end
        @(negedge clk);
        #1;
        add("rr_full", 0, 4'b1111, 0, 4'b0000, 0, 8'h00, 8, 0);
        v = vecs[$];
        check(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
